div_ctrl: RTL and testbench

- Multi-cycle controller and iterative datapath for the MIPS DIV/DIVU instructions, sitting in the EX stage beside the single-cycle ALU.
- Sequences a radix-2 restoring divider over WIDTH iterations and holds the pipeline with a stall request until the result is ready.
- Drops any in-flight operation on a pipeline flush (annul).
- Returns {remainder, quotient} for the HI/LO write-back.

---
 rtl/div_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_div_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in EX.
// Optional macro DIV_FAST_EXIT_EN: skip iterations when |dividend| < |divisor|.
// Ports:
//   clk, resetn            clock, async active-low reset
//   start, signed_div      request (held until ready), 1=DIV 0=DIVU
//   opdata1, opdata2       dividend, divisor (sampled in IDLE)
//   annul                  flush, drops the current operation
//   result                 {remainder, quotient}, registered
//   ready                  result valid, registered
//   stall_req              start & ~ready
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_req
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [CW-1:0]      r_cnt;
    logic               r_a_neg;
    logic               r_b_neg;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic               w_div0;
    logic               w_fast;
    logic               w_go;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic               w_last;

    assign w_a_neg = signed_div & opdata1[WIDTH-1];
    assign w_b_neg = signed_div & opdata2[WIDTH-1];
    assign w_a_abs = w_a_neg ? (~opdata1 + WIDTH'(1)) : opdata1;
    assign w_b_abs = w_b_neg ? (~opdata2 + WIDTH'(1)) : opdata2;
    assign w_div0  = (opdata2 == '0);
    assign w_go    = start & ~annul;

`ifdef DIV_FAST_EXIT_EN
    assign w_fast = (w_a_abs < w_b_abs);
`else
    assign w_fast = 1'b0;
`endif

    // One restoring step; the trial difference needs WIDTH+1 bits
    // because the shifted remainder can reach 2*divisor-1.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    assign w_quo_fix = (r_a_neg ^ r_b_neg) ? (~w_quo_nxt + WIDTH'(1))
                                           : w_quo_nxt;
    assign w_rem_fix = r_a_neg ? (~w_rem_nxt + WIDTH'(1)) : w_rem_nxt;

    assign result    = r_result;
    assign ready     = r_ready;
    assign stall_req = start & ~r_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    if (w_div0)
                        w_state_nxt = S_DIVZERO;
                    else if (w_fast)
                        w_state_nxt = S_END;
                    else
                        w_state_nxt = S_ON;
                end
            end
            S_DIVZERO: begin
                w_state_nxt = annul ? S_IDLE : S_END;
            end
            S_ON: begin
                if (annul)
                    w_state_nxt = S_IDLE;
                else if (w_last)
                    w_state_nxt = S_END;
            end
            S_END: begin
                if (annul || (r_ready && !start))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else if (r_state != S_IDLE && annul) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (w_go) begin
                        if (w_div0) begin
                            // Raw dividend is parked for the HI value.
                            r_quo <= opdata1;
                        end else if (w_fast) begin
                            r_result <= {opdata1, {WIDTH{1'b0}}};
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_a_abs;
                            r_dvs   <= w_b_abs;
                            r_cnt   <= '0;
                            r_a_neg <= w_a_neg;
                            r_b_neg <= w_b_neg;
                        end
                    end
                end
                S_DIVZERO: begin
                    r_result <= {r_quo, {WIDTH{1'b1}}};
                end
                S_ON: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last)
                        r_result <= {w_rem_fix, w_quo_fix};
                end
                S_END: begin
                    r_ready <= !(r_ready && !start);
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed self-checking bench for div_ctrl.
// Checks latency, stall, result, hold, release, annul and async reset.
module tb_div_ctrl;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_req;

    int checks;
    int failures;

    div_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic sd,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [63:0] exp_res);
        int   lat;
        logic stall_ok;
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        lat        = -1;
        stall_ok   = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                opdata1    = ~a;
                opdata2    = 32'h1;
                signed_div = ~sd;
            end
            if (ready === 1'b1) begin
                lat = k;
                break;
            end
            if (stall_req !== 1'b1) stall_ok = 1'b0;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " stall_busy"}, 64'(stall_ok), 64'(1));
        check({tag, " stall_done"}, 64'(stall_req), 64'(0));
        check({tag, " result"}, result, exp_res);
        repeat (2) @(posedge clk);
        #1;
        check({tag, " hold_ready"}, 64'(ready), 64'(1));
        check({tag, " hold_result"}, result, exp_res);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, " stall_off"}, 64'(stall_req), 64'(0));
        @(posedge clk);
        #1;
        check({tag, " release_ready"}, 64'(ready), 64'(0));
        check({tag, " release_result"}, result, exp_res);
    endtask

    initial begin
        int fast_lat;
        checks     = 0;
        failures   = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;
`ifdef DIV_FAST_EXIT_EN
        fast_lat = 1;
`else
        fast_lat = 33;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(ready), 64'(0));
        check("reset result", result, 64'(0));
        check("reset stall", 64'(stall_req), 64'(0));
        @(negedge clk);
        resetn = 1'b1;

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33,
              {32'd2, 32'd14});
        do_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 33,
              {32'hFFFFFFFF, 32'hFFFFFFFD});
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 33,
              {32'd1, 32'hFFFFFFFD});
        do_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33,
              {32'h0, 32'h80000000});
        do_op("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 33,
              {32'hFFFFFFFE, 32'hFFFFFFF2});
        do_op("divu_big", 1'b0, 32'hFFFFFFFF, 32'h80000000, 33,
              {32'h7FFFFFFF, 32'h1});
        do_op("divu_5_0", 1'b0, 32'd5, 32'd0, 2,
              {32'd5, 32'hFFFFFFFF});

        // annul in cycle 10 of DIVU 1000/3
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        check("annul ready", 64'(ready), 64'(0));
        check("annul result", result, 64'(0));
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("annul idle ready", 64'(ready), 64'(0));

        do_op("divu_9_3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});

        // async reset mid-ON
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        repeat (10) @(posedge clk);
        #2;
        start  = 1'b0;
        resetn = 1'b0;
        #1;
        check("rst ready", 64'(ready), 64'(0));
        check("rst result", result, 64'(0));
        check("rst stall", 64'(stall_req), 64'(0));
        @(negedge clk);
        resetn = 1'b1;

        do_op("divu_3_10", 1'b0, 32'd3, 32'd10, fast_lat,
              {32'd3, 32'd0});
        do_op("div_m3_10", 1'b1, 32'hFFFFFFFD, 32'd10, fast_lat,
              {32'hFFFFFFFD, 32'd0});
        do_op("divu_after", 1'b0, 32'd1000, 32'd3, 33,
              {32'd1, 32'd333});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
